// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game datapath: VGA timing,
// frame-update scheduler states and client slot assignments.
package pong_pkg;

   localparam int HA   = 640;
   localparam int HF   = 16;
   localparam int HS   = 96;
   localparam int HB   = 48;
   localparam int HTOT = HA + HF + HS + HB;

   localparam int VA   = 480;
   localparam int VF   = 10;
   localparam int VS   = 2;
   localparam int VB   = 33;
   localparam int VTOT = VA + VF + VS + VB;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } sched_state_t;

   localparam int CL_PADDLE_L = 0;
   localparam int CL_PADDLE_R = 1;
   localparam int CL_BALL     = 2;
   localparam int CL_SCORE    = 3;

endpackage

// File: rtl/upd_timer.sv
// Per-request wait counter: cleared between requests, incremented while a
// request is pending, flags expiry when it reaches TIMEOUT-1.
module upd_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 8'd0;
      end else if (clr_i) begin
         cnt_q <= 8'd0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/frame_update_sched.sv
// Once-per-frame update sequencer: during vertical blanking it walks the
// update clients in slot order, one req/ack transaction each.
module frame_update_sched #(
   parameter int N_CLIENTS = 4,
   parameter int TIMEOUT   = 255,
   parameter int VA        = pong_pkg::VA,
   parameter int HTOT      = pong_pkg::HTOT,
   parameter int VTOT      = pong_pkg::VTOT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 pix_en_i,
   input  logic [9:0]           pos_x_i,
   input  logic [9:0]           pos_y_i,
   output logic [N_CLIENTS-1:0] upd_req_o,
   input  logic [N_CLIENTS-1:0] upd_ack_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [15:0]          frame_cnt_o,
   output logic [N_CLIENTS-1:0] timeout_err_o,
   output logic                 overrun_o,
   input  logic                 err_clr_i
);
   import pong_pkg::*;

   localparam int SLOT_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CLIENTS - 1);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_REQ  = REQ;
   localparam logic [1:0] S_GAP  = GAP;
   localparam logic [1:0] S_DONE = DONE;
   // Frame events only exist for timing where the start line lies inside the frame.
   localparam bit TIMING_OK = (VA > 0) && (VA < VTOT) && (HTOT > 0);

   logic [1:0]           state_q, state_d;
   logic [SLOT_W-1:0]    slot_q, slot_d;
   logic [15:0]          frame_cnt_q;
   logic [N_CLIENTS-1:0] tout_q, tout_set;
   logic                 ovr_q, ovr_set;
   logic                 cnt_inc;
   logic                 timer_clr, timer_inc, timer_exp;
   logic                 fs, av;

   assign fs = TIMING_OK && pix_en_i && (pos_x_i == 10'd0) && (pos_y_i == 10'(VA));
   assign av = TIMING_OK && pix_en_i && (pos_x_i == 10'd0) && (pos_y_i == 10'd0);

   upd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (timer_clr),
      .inc_i     (timer_inc),
      .expired_o (timer_exp)
   );

   // Handshake: upd_req_o[slot] stays high until the client raises
   // upd_ack_i[slot] on a clock edge (or the timer expires); the request
   // then drops for at least one cycle before the next slot is asked.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      timer_clr = 1'b1;
      timer_inc = 1'b0;
      tout_set  = '0;
      ovr_set   = 1'b0;
      cnt_inc   = 1'b0;
      if ((state_q != S_IDLE) && av) begin
         state_d = S_IDLE;
         slot_d  = '0;
         ovr_set = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fs && en_i) begin
                  state_d = S_REQ;
                  slot_d  = '0;
               end
            end
            S_REQ: begin
               if (upd_ack_i[slot_q]) begin
                  state_d = S_GAP;
               end else if (timer_exp) begin
                  tout_set[slot_q] = 1'b1;
                  state_d          = S_GAP;
               end else begin
                  timer_clr = 1'b0;
                  timer_inc = 1'b1;
               end
            end
            S_GAP: begin
               if (slot_q == LAST_SLOT) begin
                  state_d = S_DONE;
               end else begin
                  slot_d  = SLOT_W'(slot_q + 1'b1);
                  state_d = S_REQ;
               end
            end
            S_DONE: begin
               cnt_inc = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         slot_q      <= '0;
         frame_cnt_q <= 16'd0;
         tout_q      <= '0;
         ovr_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         if (cnt_inc) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
         // A set in the same cycle as a clear wins for that bit.
         tout_q <= (tout_q & ~{N_CLIENTS{err_clr_i}}) | tout_set;
         ovr_q  <= (ovr_q & ~err_clr_i) | ovr_set;
      end
   end

   always_comb begin
      upd_req_o = '0;
      if (state_q == S_REQ) begin
         upd_req_o[slot_q] = 1'b1;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign frame_cnt_o   = frame_cnt_q;
   assign timeout_err_o = tout_q;
   assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Self-checking bench for frame_update_sched: table of whole-frame vectors
// plus hand-written abort, sticky-clear, enable and async-reset sequences.
module tb_frame_update_sched;

   localparam int N   = 4;
   localparam int TMO = 255;
   localparam int FS_Y = 480;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic        pix_en_i = 1'b0;
   logic [9:0]  pos_x_i = 10'd1;
   logic [9:0]  pos_y_i = 10'd100;
   logic [N-1:0] upd_req_o;
   logic [N-1:0] upd_ack_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [15:0] frame_cnt_o;
   logic [N-1:0] timeout_err_o;
   logic        overrun_o;
   logic        err_clr_i = 1'b0;

   frame_update_sched #(.N_CLIENTS(N), .TIMEOUT(TMO)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .pix_en_i      (pix_en_i),
      .pos_x_i       (pos_x_i),
      .pos_y_i       (pos_y_i),
      .upd_req_o     (upd_req_o),
      .upd_ack_i     (upd_ack_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .frame_cnt_o   (frame_cnt_o),
      .timeout_err_o (timeout_err_o),
      .overrun_o     (overrun_o),
      .err_clr_i     (err_clr_i)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: each entry is {req one-hot, high length in cycles}
   logic [15:0] exp_q[$];
   logic [N-1:0] prev_req = '0;
   int           seg_len = 0;
   bit           mon_en = 1'b1;
   logic [N-1:0] never_mask = '0;
   int           ack_delay = 2;
   bit           junk_ack = 1'b0;
   int           done_cnt = 0;
   int           exp_cnt = 0;

   // monitor and client model
   always @(negedge clk_i) begin
      logic [15:0]  e;
      logic [N-1:0] ack;
      if (done_o) done_cnt++;
      if (mon_en && prev_req != '0 && upd_req_o != prev_req) begin
         check("req_gap", 32'(upd_req_o), 32'h0);
         if (exp_q.size() == 0) begin
            check("req_unexpected", 32'({prev_req, 12'(seg_len)}), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check("req_seg", 32'({prev_req, 12'(seg_len)}), 32'(e));
         end
      end
      if (upd_req_o != '0 && upd_req_o == prev_req) seg_len++;
      else seg_len = 1;
      prev_req = upd_req_o;
      ack = '0;
      if (upd_req_o != '0 && seg_len > ack_delay && (upd_req_o & never_mask) == '0)
         ack = upd_req_o;
      if (junk_ack) ack = ack | ~upd_req_o;
      upd_ack_i = ack;
   end

   // driver tasks
   task automatic drive_fs(input logic en);
      @(negedge clk_i);
      en_i = en; pix_en_i = 1'b1; pos_x_i = 10'd0; pos_y_i = 10'(FS_Y);
      @(negedge clk_i);
      pix_en_i = 1'b0; pos_x_i = 10'd1;
   endtask

   task automatic drive_av();
      @(negedge clk_i);
      pix_en_i = 1'b1; pos_x_i = 10'd0; pos_y_i = 10'd0;
      @(negedge clk_i);
      pix_en_i = 1'b0; pos_x_i = 10'd1;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check("wait_idle", 32'(busy_o), 32'h0);
   endtask

   task automatic wait_req(input logic [N-1:0] r, input int budget);
      int n = 0;
      while (upd_req_o != r && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check("wait_req", 32'(upd_req_o), 32'(r));
   endtask

   task automatic push_frame(input int delay, input logic [N-1:0] never);
      for (int s = 0; s < N; s++) begin
         exp_q.push_back({4'(1 << s), 12'(never[s] ? TMO : delay + 1)});
      end
   endtask

   typedef struct {
      logic       en;
      int         delay;
      logic [3:0] never;
      logic       junk;
      logic       exp_done;
      logic       exp_inc;
      logic [3:0] exp_tout;
   } fvec_t;

   fvec_t tbl[6];

   task automatic run_frame(input fvec_t v);
      int d0;
      ack_delay = v.delay; never_mask = v.never; junk_ack = v.junk;
      d0 = done_cnt;
      if (v.en) push_frame(v.delay, v.never);
      drive_fs(v.en);
      wait_idle(2000);
      repeat (3) @(negedge clk_i);
      if (v.exp_inc) exp_cnt = (exp_cnt + 1) % 65536;
      check("done_pulses", 32'(done_cnt - d0), 32'(v.exp_done));
      check("frame_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
      check("timeout_err", 32'(timeout_err_o), 32'(v.exp_tout));
      check("overrun_clean", 32'(overrun_o), 32'h0);
      check("sb_empty", 32'(exp_q.size()), 32'h0);
      junk_ack = 1'b0;
      pulse_err_clr();
      check("err_cleared", 32'({overrun_o, timeout_err_o}), 32'h0);
   endtask

   initial begin
      int c0, d0;
      tbl[0] = '{1'b1, 2, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000};
      tbl[1] = '{1'b0, 2, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
      tbl[2] = '{1'b1, 2, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100};
      tbl[3] = '{1'b1, 0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000};
      tbl[4] = '{1'b1, 6, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1001};
      tbl[5] = '{1'b1, $urandom_range(1, 5), 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000};

      // reset state
      repeat (2) @(negedge clk_i);
      check("rst_req", 32'(upd_req_o), 32'h0);
      check("rst_flags", 32'({busy_o, done_o, overrun_o, timeout_err_o}), 32'h0);
      check("rst_cnt", 32'(frame_cnt_o), 32'h0);
      rst_i = 1'b0;

      // near-miss frame starts are ignored
      @(negedge clk_i);
      en_i = 1'b1; pix_en_i = 1'b0; pos_x_i = 10'd0; pos_y_i = 10'(FS_Y);
      @(negedge clk_i);
      pix_en_i = 1'b1; pos_x_i = 10'd3;
      @(negedge clk_i);
      check("fs_no_pixen", 32'(busy_o), 32'h0);
      pix_en_i = 1'b0; pos_x_i = 10'd1;
      @(negedge clk_i);
      check("fs_wrong_x", 32'(busy_o), 32'h0);

      for (int i = 0; i < 6; i++) run_frame(tbl[i]);

      // overrun: active video resumes while slot 1 is still waiting
      mon_en = 1'b0; never_mask = 4'b0010; ack_delay = 2;
      c0 = frame_cnt_o; d0 = done_cnt;
      drive_fs(1'b1);
      wait_req(4'b0010, 200);
      repeat (10) @(negedge clk_i);
      drive_av();
      check("ovr_req", 32'(upd_req_o), 32'h0);
      check("ovr_busy", 32'(busy_o), 32'h0);
      check("ovr_flag", 32'(overrun_o), 32'h1);
      check("ovr_cnt", 32'(frame_cnt_o), 32'(c0));
      repeat (5) @(negedge clk_i);
      check("ovr_no_done", 32'(done_cnt - d0), 32'h0);
      mon_en = 1'b1;

      // sticky clear, then clear colliding with a slot-0 timeout
      pulse_err_clr();
      check("ovr_cleared", 32'(overrun_o), 32'h0);
      never_mask = 4'b0001; ack_delay = 2;
      push_frame(2, 4'b0001);
      drive_fs(1'b1);
      check("tmo_first_req", 32'(upd_req_o), 32'h1);
      repeat (TMO - 1) @(negedge clk_i);
      check("tmo_last_req", 32'(upd_req_o), 32'h1);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      check("set_beats_clr", 32'(timeout_err_o), 32'h1);
      check("tmo_gap", 32'(upd_req_o), 32'h0);
      wait_idle(2000);
      exp_cnt = (exp_cnt + 1) % 65536;
      check("tmo_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
      check("tmo_sb_empty", 32'(exp_q.size()), 32'h0);
      pulse_err_clr();
      check("tmo_cleared", 32'(timeout_err_o), 32'h0);

      // en_i dropped mid-sequence: frame still completes
      never_mask = '0; ack_delay = 2; d0 = done_cnt;
      push_frame(2, 4'b0000);
      drive_fs(1'b1);
      wait_req(4'b0010, 200);
      en_i = 1'b0;
      wait_idle(2000);
      @(negedge clk_i);
      exp_cnt = (exp_cnt + 1) % 65536;
      check("en_drop_done", 32'(done_cnt - d0), 32'h1);
      check("en_drop_cnt", 32'(frame_cnt_o), 32'(exp_cnt));
      check("en_drop_sb", 32'(exp_q.size()), 32'h0);

      // asynchronous reset during slot 2
      mon_en = 1'b0;
      drive_fs(1'b1);
      wait_req(4'b0100, 200);
      #2 rst_i = 1'b1;
      #1;
      check("arst_req", 32'(upd_req_o), 32'h0);
      check("arst_cnt", 32'(frame_cnt_o), 32'h0);
      check("arst_busy", 32'(busy_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      exp_cnt = 0;
      @(negedge clk_i);
      mon_en = 1'b1;
      run_frame(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
